// File: rtl/dvp_rgb565_unpack_if.sv
// Three-lane pixel output bus: lane 0 = R, lane 1 = G, lane 2 = B, all lanes valid together.
interface dvp_rgb565_unpack_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic [2:0][DATA_WIDTH-1:0] data;
    logic [2:0]                 valid;

    modport master (output data, valid);
    modport slave  (input  data, valid);
endinterface

// File: rtl/dvp_rgb565_unpack.sv
// DVP byte stream to RGB888 lanes: pairs camera bytes into RGB565 pixels, expands each
// channel to 8 bits, tracks x/y position, drops settling frames and flags bad geometry.
module dvp_rgb565_unpack #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned SKIP_FRAMES = 10
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cam_vsync,
    input  logic                        cam_href,
    input  logic [7:0]                  cam_data,
    dvp_rgb565_unpack_if.master         out,
    output logic [$clog2(H_ACTIVE)-1:0] x_pos,
    output logic [$clog2(V_ACTIVE)-1:0] y_pos,
    output logic                        frame_start,
    output logic                        line_end,
    output logic [15:0]                 frame_cnt,
    output logic                        size_err,
    output logic                        active
);
    localparam int unsigned XW  = $clog2(H_ACTIVE);
    localparam int unsigned YW  = $clog2(V_ACTIVE);
    // Position counters need one extra bit so they can reach H_ACTIVE / V_ACTIVE.
    localparam int unsigned XCW = XW + 1;
    localparam int unsigned YCW = YW + 1;
    localparam int unsigned SKW = (SKIP_FRAMES < 2) ? 1 : $clog2(SKIP_FRAMES + 1);

    typedef enum logic [1:0] {
        ST_WAIT_SYNC = 2'd0,
        ST_SKIP      = 2'd1,
        ST_ACTIVE    = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [SKW-1:0]   skip_cnt;
    logic [SKW-1:0]   skip_next;

    logic             vsync_r;
    logic             href_r;
    logic [7:0]       data_r;
    logic             vsync_d;
    logic             href_d;
    logic             vsync_rise;
    logic             href_fall;

    logic             phase;
    logic [7:0]       hi_byte;
    logic [XCW-1:0]   x_cnt;
    logic [YCW-1:0]   y_cnt;
    logic             in_frame;

    logic [4:0]       r5;
    logic [5:0]       g6;
    logic [4:0]       b5;
    logic [7:0]       r8;
    logic [7:0]       g8;
    logic [7:0]       b8;

    // Camera inputs are registered once; edges are detected on the registered copies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_r <= 1'b0;
            href_r  <= 1'b0;
            data_r  <= 8'd0;
            vsync_d <= 1'b0;
            href_d  <= 1'b0;
        end else begin
            vsync_r <= cam_vsync;
            href_r  <= cam_href;
            data_r  <= cam_data;
            vsync_d <= vsync_r;
            href_d  <= href_r;
        end
    end

    assign vsync_rise = vsync_r & ~vsync_d;
    assign href_fall  = ~href_r & href_d;

    // RGB565 split across the held phase-0 byte and the current phase-1 byte, then bit-replicated.
    assign r5 = hi_byte[7:3];
    assign g6 = {hi_byte[2:0], data_r[7:5]};
    assign b5 = data_r[4:0];
    assign r8 = {r5, r5[4:2]};
    assign g8 = {g6, g6[5:4]};
    assign b8 = {b5, b5[4:2]};

    assign in_frame = (x_cnt < XCW'(H_ACTIVE)) && (y_cnt < YCW'(V_ACTIVE));

    // Frame-gating state register; active mirrors the ACTIVE state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_WAIT_SYNC;
            skip_cnt <= '0;
            active   <= 1'b0;
        end else begin
            state    <= state_next;
            skip_cnt <= skip_next;
            active   <= (state_next == ST_ACTIVE);
        end
    end

    // Next-state: count settling frames on vsync rises, then stay ACTIVE until reset.
    always_comb begin
        state_next = state;
        skip_next  = skip_cnt;
        case (state)
            ST_WAIT_SYNC: begin
                if (vsync_rise) begin
                    if (SKIP_FRAMES == 0) begin
                        state_next = ST_ACTIVE;
                    end else begin
                        state_next = ST_SKIP;
                        skip_next  = SKW'(1);
                    end
                end
            end
            ST_SKIP: begin
                if (vsync_rise) begin
                    if (skip_cnt == SKW'(SKIP_FRAMES)) begin
                        state_next = ST_ACTIVE;
                    end else begin
                        skip_next = skip_cnt + SKW'(1);
                    end
                end
            end
            default: begin
                state_next = state;
            end
        endcase
    end

    // Byte pairing, position tracking, pixel emission and geometry checking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase       <= 1'b0;
            hi_byte     <= 8'd0;
            x_cnt       <= '0;
            y_cnt       <= '0;
            out.valid   <= '0;
            out.data    <= '0;
            x_pos       <= '0;
            y_pos       <= '0;
            frame_start <= 1'b0;
            line_end    <= 1'b0;
            frame_cnt   <= 16'd0;
            size_err    <= 1'b0;
        end else begin
            out.valid   <= '0;
            frame_start <= 1'b0;
            line_end    <= 1'b0;
            if (vsync_rise) begin
                // New frame wins over any byte or line end in the same cycle.
                phase <= 1'b0;
                x_cnt <= '0;
                y_cnt <= '0;
            end else if (href_r) begin
                phase <= ~phase;
                if (!phase) begin
                    hi_byte <= data_r;
                end else if (state == ST_ACTIVE) begin
                    if (in_frame) begin
                        out.valid   <= '1;
                        out.data[0] <= DATA_WIDTH'(r8);
                        out.data[1] <= DATA_WIDTH'(g8);
                        out.data[2] <= DATA_WIDTH'(b8);
                        x_pos       <= x_cnt[XW-1:0];
                        y_pos       <= y_cnt[YW-1:0];
                        frame_start <= (x_cnt == '0) && (y_cnt == '0);
                        line_end    <= (x_cnt == XCW'(H_ACTIVE - 1));
                        if ((x_cnt == '0) && (y_cnt == '0)) begin
                            frame_cnt <= frame_cnt + 16'd1;
                        end
                        x_cnt <= x_cnt + XCW'(1);
                    end else begin
                        size_err <= 1'b1;
                    end
                end
            end else begin
                phase <= 1'b0;
                // x only advances on emitted pixels, so a non-zero x means the line produced output.
                if (href_fall && (x_cnt != '0)) begin
                    if (x_cnt < XCW'(H_ACTIVE)) begin
                        size_err <= 1'b1;
                    end
                    y_cnt <= y_cnt + YCW'(1);
                    x_cnt <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_dvp_rgb565_unpack.sv
// Bench for dvp_rgb565_unpack: two instances (no settling frames / two settling frames) share
// one random camera stream; a frame/line-level model predicts every pixel, its cycle and status.
module tb_dvp_rgb565_unpack;
    localparam int DW = 16;
    localparam int H  = 4;
    localparam int V  = 2;

    typedef struct packed {
        logic [2:0]    valid;
        logic [DW-1:0] r;
        logic [DW-1:0] g;
        logic [DW-1:0] b;
        logic [7:0]    x;
        logic [7:0]    y;
        logic          fs;
        logic          le;
        logic [31:0]   cyc;
    } pix_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cam_vsync;
    logic        cam_href;
    logic [7:0]  cam_data;

    logic [1:0]  x_a, x_b;
    logic [0:0]  y_a, y_b;
    logic        fs_a, fs_b, le_a, le_b, err_a, err_b, act_a, act_b;
    logic [15:0] fc_a, fc_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stray_a = 0;
    int stray_b = 0;

    pix_t got_a[$];
    pix_t got_b[$];
    pix_t exp_a[$];
    pix_t exp_b[$];
    int   gb[2];
    int   eb[2];

    // Model state: frames seen since reset, current row, sticky error, frames emitted.
    int   frames[2];
    int   my[2];
    bit   merr[2];
    int   mfcnt[2];
    int   skipn[2] = '{0, 2};
    logic [7:0] forced[$];

    dvp_rgb565_unpack_if #(.DATA_WIDTH(DW)) if_a ();
    dvp_rgb565_unpack_if #(.DATA_WIDTH(DW)) if_b ();

    dvp_rgb565_unpack #(.DATA_WIDTH(DW), .H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
        .out(if_a), .x_pos(x_a), .y_pos(y_a), .frame_start(fs_a), .line_end(le_a),
        .frame_cnt(fc_a), .size_err(err_a), .active(act_a)
    );

    dvp_rgb565_unpack #(.DATA_WIDTH(DW), .H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
        .out(if_b), .x_pos(x_b), .y_pos(y_b), .frame_start(fs_b), .line_end(le_b),
        .frame_cnt(fc_b), .size_err(err_b), .active(act_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every output pixel with the cycle it was seen in.
    always @(negedge clk) begin
        if (if_a.valid != 3'b000)
            got_a.push_back({if_a.valid, if_a.data[0], if_a.data[1], if_a.data[2],
                             8'(x_a), 8'(y_a), fs_a, le_a, 32'(cyc)});
        else if (fs_a || le_a)
            stray_a++;
        if (if_b.valid != 3'b000)
            got_b.push_back({if_b.valid, if_b.data[0], if_b.data[1], if_b.data[2],
                             8'(x_b), 8'(y_b), fs_b, le_b, 32'(cyc)});
        else if (fs_b || le_b)
            stray_b++;
    end

    function automatic int qlen(input bit e, input int d);
        if (e) return (d == 0) ? exp_a.size() - eb[0] : exp_b.size() - eb[1];
        return (d == 0) ? got_a.size() - gb[0] : got_b.size() - gb[1];
    endfunction

    function automatic pix_t pick(input bit e, input int d, input int i);
        if (e) return (d == 0) ? exp_a[eb[0] + i] : exp_b[eb[1] + i];
        return (d == 0) ? got_a[gb[0] + i] : got_b[gb[1] + i];
    endfunction

    function automatic bit mact(input int d);
        return frames[d] > skipn[d];
    endfunction

    function automatic logic [18:0] dut_status(input int d);
        if (d == 0) return {fc_a, err_a, act_a, stray_a != 0};
        return {fc_b, err_b, act_b, stray_b != 0};
    endfunction

    function automatic logic [18:0] model_status(input int d);
        return {16'(mfcnt[d]), merr[d], mact(d), 1'b0};
    endfunction

    task automatic mark();
        gb[0] = got_a.size();
        gb[1] = got_b.size();
        eb[0] = exp_a.size();
        eb[1] = exp_b.size();
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            frames[d] = 0;
            my[d]     = 0;
            merr[d]   = 1'b0;
            mfcnt[d]  = 0;
        end
    endtask

    task automatic model_vsync();
        for (int d = 0; d < 2; d++) begin
            frames[d]++;
            my[d] = 0;
        end
    endtask

    // Pixel k of the current line, completed by byte lo presented in cycle c.
    task automatic model_pixel(input int k, input logic [7:0] hi, input logic [7:0] lo, input int c);
        int   v, r5, g6, b5;
        pix_t p;
        v  = int'(hi) * 256 + int'(lo);
        r5 = v / 2048;
        g6 = (v / 32) % 64;
        b5 = v % 32;
        for (int d = 0; d < 2; d++) begin
            if (mact(d)) begin
                if (k < H && my[d] < V) begin
                    p = {3'b111, DW'(r5 * 8 + r5 / 4), DW'(g6 * 4 + g6 / 16), DW'(b5 * 8 + b5 / 4),
                         8'(k), 8'(my[d]), (k == 0 && my[d] == 0), (k == H - 1), 32'(c + 2)};
                    if (k == 0 && my[d] == 0) mfcnt[d]++;
                    if (d == 0) exp_a.push_back(p);
                    else exp_b.push_back(p);
                end else begin
                    merr[d] = 1'b1;
                end
            end
        end
    endtask

    task automatic model_line_end(input int npix);
        int em;
        for (int d = 0; d < 2; d++) begin
            if (mact(d)) begin
                em = (my[d] < V) ? ((npix < H) ? npix : H) : 0;
                if (em > 0 && em < H) merr[d] = 1'b1;
                if (em > 0) my[d]++;
            end
        end
    endtask

    task automatic step(input logic vs, input logic hr, input logic [7:0] d, output int c);
        @(posedge clk);
        #1;
        cam_vsync = vs;
        cam_href  = hr;
        cam_data  = d;
        c = cyc;
    endtask

    task automatic idle(input int n);
        int c;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'd0, c);
    endtask

    task automatic send_vsync();
        int c;
        step(1'b1, 1'b0, 8'd0, c);
        model_vsync();
        step(1'b1, 1'b0, 8'd0, c);
        idle(3);
    endtask

    task automatic send_line(input int n, input int gap);
        logic [7:0] hi, b;
        int c;
        hi = 8'd0;
        for (int i = 0; i < n; i++) begin
            b = (forced.size() > 0) ? forced.pop_front() : 8'($urandom);
            step(1'b0, 1'b1, b, c);
            if (i % 2 == 0) hi = b;
            else model_pixel(i / 2, hi, b, c);
        end
        for (int i = 0; i < gap; i++) step(1'b0, 1'b0, 8'($urandom), c);
        model_line_end(n / 2);
    endtask

    task automatic send_frame(input int nlines);
        send_vsync();
        for (int l = 0; l < nlines; l++) send_line(2 * H, $urandom_range(1, 3));
    endtask

    task automatic test_reset();
        cam_vsync = 1'b0;
        cam_href  = 1'b0;
        cam_data  = 8'd0;
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({if_a.valid, if_a.data, x_a, y_a, fs_a, le_a, fc_a, err_a, act_a} !== '0) begin
            errors++;
            $display("FAIL reset dut0 outputs: got %h required 0", {if_a.valid, if_a.data, x_a, y_a, fs_a, le_a, fc_a, err_a, act_a});
        end
        checks++;
        if ({if_b.valid, if_b.data, x_b, y_b, fs_b, le_b, fc_b, err_b, act_b} !== '0) begin
            errors++;
            $display("FAIL reset dut1 outputs: got %h required 0", {if_b.valid, if_b.data, x_b, y_b, fs_b, le_b, fc_b, err_b, act_b});
        end
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        mark();
    endtask

    task automatic test_skip();
        mark();
        for (int f = 0; f < 3; f++) send_frame(V);
        idle(4);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (qlen(0, d) !== qlen(1, d)) begin
                errors++;
                $display("FAIL skip count dut%0d: got %0d pixels, expected %0d", d, qlen(0, d), qlen(1, d));
            end
            for (int i = 0; i < qlen(0, d) && i < qlen(1, d); i++) begin
                checks++;
                if (pick(0, d, i) !== pick(1, d, i)) begin
                    errors++;
                    $display("FAIL skip pixel dut%0d #%0d: got %h expected %h", d, i, pick(0, d, i), pick(1, d, i));
                end
            end
            checks++;
            if (dut_status(d) !== model_status(d)) begin
                errors++;
                $display("FAIL skip status dut%0d: got %h expected %h", d, dut_status(d), model_status(d));
            end
        end
    endtask

    task automatic test_colour();
        pix_t p;
        mark();
        forced = '{8'hF8, 8'h1F, 8'h07, 8'hE0};
        send_frame(V);
        idle(4);
        p = pick(0, 0, 0);
        checks++;
        if ({p.r, p.g, p.b} !== {16'd255, 16'd0, 16'd255}) begin
            errors++;
            $display("FAIL colour magenta: got r=%0d g=%0d b=%0d required 255/0/255", p.r, p.g, p.b);
        end
        p = pick(0, 0, 1);
        checks++;
        if ({p.r, p.g, p.b} !== {16'd0, 16'd255, 16'd0}) begin
            errors++;
            $display("FAIL colour green: got r=%0d g=%0d b=%0d required 0/255/0", p.r, p.g, p.b);
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (qlen(0, d) !== qlen(1, d)) begin
                errors++;
                $display("FAIL colour count dut%0d: got %0d pixels, expected %0d", d, qlen(0, d), qlen(1, d));
            end
            for (int i = 0; i < qlen(0, d) && i < qlen(1, d); i++) begin
                checks++;
                if (pick(0, d, i) !== pick(1, d, i)) begin
                    errors++;
                    $display("FAIL colour pixel dut%0d #%0d: got %h expected %h", d, i, pick(0, d, i), pick(1, d, i));
                end
            end
            checks++;
            if (dut_status(d) !== model_status(d)) begin
                errors++;
                $display("FAIL colour status dut%0d: got %h expected %h", d, dut_status(d), model_status(d));
            end
        end
    endtask

    task automatic test_random();
        mark();
        for (int f = 0; f < 5; f++) send_frame($urandom_range(1, V));
        idle(4);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (qlen(0, d) !== qlen(1, d)) begin
                errors++;
                $display("FAIL random count dut%0d: got %0d pixels, expected %0d", d, qlen(0, d), qlen(1, d));
            end
            for (int i = 0; i < qlen(0, d) && i < qlen(1, d); i++) begin
                checks++;
                if (pick(0, d, i) !== pick(1, d, i)) begin
                    errors++;
                    $display("FAIL random pixel dut%0d #%0d: got %h expected %h", d, i, pick(0, d, i), pick(1, d, i));
                end
            end
            checks++;
            if (dut_status(d) !== model_status(d)) begin
                errors++;
                $display("FAIL random status dut%0d: got %h expected %h", d, dut_status(d), model_status(d));
            end
        end
    endtask

    task automatic test_abort();
        logic [7:0] hi, b;
        int c;
        mark();
        send_vsync();
        send_line(2 * H, 2);
        hi = 8'd0;
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            step(1'b0, 1'b1, b, c);
            if (i == 0) hi = b;
            else if (i == 1) model_pixel(0, hi, b, c);
        end
        // vsync rises while the line is still running: the partial pixel must vanish.
        step(1'b1, 1'b1, 8'($urandom), c);
        model_vsync();
        step(1'b1, 1'b0, 8'd0, c);
        idle(3);
        send_line(2 * H, 2);
        send_line(2 * H, 2);
        idle(4);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (qlen(0, d) !== qlen(1, d)) begin
                errors++;
                $display("FAIL abort count dut%0d: got %0d pixels, expected %0d", d, qlen(0, d), qlen(1, d));
            end
            for (int i = 0; i < qlen(0, d) && i < qlen(1, d); i++) begin
                checks++;
                if (pick(0, d, i) !== pick(1, d, i)) begin
                    errors++;
                    $display("FAIL abort pixel dut%0d #%0d: got %h expected %h", d, i, pick(0, d, i), pick(1, d, i));
                end
            end
            checks++;
            if (dut_status(d) !== model_status(d)) begin
                errors++;
                $display("FAIL abort status dut%0d: got %h expected %h", d, dut_status(d), model_status(d));
            end
        end
    endtask

    task automatic test_geometry();
        mark();
        send_vsync();
        send_line(11, 2);
        send_line(2 * H, 2);
        send_line(2 * H, 2);
        idle(4);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (qlen(0, d) !== qlen(1, d)) begin
                errors++;
                $display("FAIL geometry count dut%0d: got %0d pixels, expected %0d", d, qlen(0, d), qlen(1, d));
            end
            for (int i = 0; i < qlen(0, d) && i < qlen(1, d); i++) begin
                checks++;
                if (pick(0, d, i) !== pick(1, d, i)) begin
                    errors++;
                    $display("FAIL geometry pixel dut%0d #%0d: got %h expected %h", d, i, pick(0, d, i), pick(1, d, i));
                end
            end
            checks++;
            if (dut_status(d) !== model_status(d)) begin
                errors++;
                $display("FAIL geometry status dut%0d: got %h expected %h", d, dut_status(d), model_status(d));
            end
        end
    endtask

    task automatic test_reset_midline();
        logic [7:0] hi, b;
        int c;
        mark();
        send_vsync();
        hi = 8'd0;
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            step(1'b0, 1'b1, b, c);
            if (i % 2 == 0) hi = b;
            else if (i < 6) model_pixel(i / 2, hi, b, c);
        end
        #5 rst_n = 1'b0;
        cam_href = 1'b0;
        #1;
        checks++;
        if ({if_a.valid, if_a.data, x_a, y_a, fs_a, le_a, fc_a, err_a, act_a} !== '0) begin
            errors++;
            $display("FAIL midline_reset dut0 outputs: got %h required 0", {if_a.valid, if_a.data, x_a, y_a, fs_a, le_a, fc_a, err_a, act_a});
        end
        checks++;
        if ({if_b.valid, if_b.data, x_b, y_b, fs_b, le_b, fc_b, err_b, act_b} !== '0) begin
            errors++;
            $display("FAIL midline_reset dut1 outputs: got %h required 0", {if_b.valid, if_b.data, x_b, y_b, fs_b, le_b, fc_b, err_b, act_b});
        end
        model_reset();
        idle(2);
        #3 rst_n = 1'b1;
        send_line(2 * H, 2);
        send_frame(V);
        send_vsync();
        send_line(H, 2);
        idle(4);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (qlen(0, d) !== qlen(1, d)) begin
                errors++;
                $display("FAIL midline_reset count dut%0d: got %0d pixels, expected %0d", d, qlen(0, d), qlen(1, d));
            end
            for (int i = 0; i < qlen(0, d) && i < qlen(1, d); i++) begin
                checks++;
                if (pick(0, d, i) !== pick(1, d, i)) begin
                    errors++;
                    $display("FAIL midline_reset pixel dut%0d #%0d: got %h expected %h", d, i, pick(0, d, i), pick(1, d, i));
                end
            end
            checks++;
            if (dut_status(d) !== model_status(d)) begin
                errors++;
                $display("FAIL midline_reset status dut%0d: got %h expected %h", d, dut_status(d), model_status(d));
            end
        end
    endtask

    initial begin
        test_reset();
        test_skip();
        test_colour();
        test_random();
        test_abort();
        test_geometry();
        test_reset_midline();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
